mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller that owns HI/LO result generation for the MIPS core.
- EX issues MULT/MULTU/DIV/DIVU with forwarded rs/rt operands.
- The block runs an iterative shift-add multiplier or a restoring divider, holds the pipeline via stallreq, then pulses HI/LO writes toward MEM/WB.
- It sits beside EX and shares the EX stall/forwarding path with the HI/LO bypass into ID.

---
 rtl/mdu_ctrl.sv | 145 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/restoring-divide controller producing HI/LO writes.
// Optional MDU_FAST_MUL_EN: single-cycle array multiply, divide stays iterative.
module mdu_ctrl #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] DIV0_Q = {XLEN{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            cancel,
    output logic            stallreq,
    output logic            busy,
    output logic            done,
    output logic            hi_we,
    output logic            lo_we,
    output logic [XLEN-1:0] hi_wdata,
    output logic [XLEN-1:0] lo_wdata
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_nx;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [CW-1:0]     cnt;
    logic              neg_q, neg_r, is_mul;

    logic              sgn, go, div0;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   diff;
    logic              nb;
    logic [2*XLEN-1:0] div_next, pneg;
    logic [XLEN-1:0]   rneg, hi_res, lo_res;

    assign sgn  = ~op[0];
    assign go   = start & ~cancel & (state == IDLE);
    assign div0 = op[1] & (src2 == '0);
    assign mag1 = (sgn && src1[XLEN-1]) ? -src1 : src1;
    assign mag2 = (sgn && src2[XLEN-1]) ? -src2 : src2;

    // acc holds {remainder, quotient-being-built}; each step shifts the next dividend bit in
    assign trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign nb       = trial >= {1'b0, opnd};
    assign diff     = trial[XLEN-1:0] - opnd;
    assign div_next = {nb ? diff : trial[XLEN-1:0], acc[XLEN-2:0], nb};

`ifndef MDU_FAST_MUL_EN
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    // acc holds {partial product, remaining multiplier bits}; add then shift right
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
`endif

    // a signed product is negated as one 2*XLEN value; quotient/remainder separately
    assign pneg   = -acc;
    assign rneg   = -acc[2*XLEN-1:XLEN];
    assign lo_res = neg_q ? pneg[XLEN-1:0] : acc[XLEN-1:0];
    assign hi_res = neg_r ? (is_mul ? pneg[2*XLEN-1:XLEN] : rneg) : acc[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_mul <= 1'b0;
        end else if (go) begin
            opnd   <= op[1] ? mag2 : mag1;
`ifdef MDU_FAST_MUL_EN
            acc    <= div0 ? {src1, DIV0_Q} : op[1] ? {{XLEN{1'b0}}, mag1}
                    : {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`else
            acc    <= div0 ? {src1, DIV0_Q} : {{XLEN{1'b0}}, op[1] ? mag1 : mag2};
`endif
            neg_q  <= ~div0 & sgn & (src1[XLEN-1] ^ src2[XLEN-1]);
            neg_r  <= ~div0 & sgn & (op[1] ? src1[XLEN-1] : src1[XLEN-1] ^ src2[XLEN-1]);
            is_mul <= ~op[1];
            cnt    <= CW'(XLEN);
`ifndef MDU_FAST_MUL_EN
        end else if (state == MUL) begin
            acc <= mul_next;
            cnt <= cnt - CW'(1);
`endif
        end else if (state == DIV) begin
            acc <= div_next;
            cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        stallreq = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                stallreq = go;
`ifdef MDU_FAST_MUL_EN
                if (go) state_nx = (op[1] && !div0) ? DIV : DONE;
`else
                if (go) state_nx = op[1] ? (div0 ? DONE : DIV) : MUL;
`endif
            end
`ifndef MDU_FAST_MUL_EN
            MUL: begin
                stallreq = 1'b1;
                if (cnt == CW'(1)) state_nx = DONE;
            end
`endif
            DIV: begin
                stallreq = 1'b1;
                if (cnt == CW'(1)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (cancel) begin
            state_nx = IDLE;
            stallreq = 1'b0;
            done     = 1'b0;
        end
    end

    assign busy     = state != IDLE;
    assign hi_we    = done;
    assign lo_we    = done;
    assign hi_wdata = done ? hi_res : '0;
    assign lo_wdata = done ? lo_res : '0;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed + random scoreboard bench for mdu_ctrl.
module tb_mdu_ctrl;
    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    logic            clk = 1'b0, rst = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [1:0]      op = '0;
    logic [XLEN-1:0] src1 = '0, src2 = '0;
    logic            stallreq, busy, done, hi_we, lo_we;
    logic [XLEN-1:0] hi_wdata, lo_wdata;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .stallreq(stallreq), .busy(busy), .done(done),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input string tag);
        exp_t   e;
        longint sa, sb, q, r;
        logic [63:0] p;
        e.tag = tag;
        sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
        sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
        if (!o[1]) begin
            p     = sa * sb;
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = MUL_LAT;
        end else if (b == 0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.lat = 1;
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            e.hi  = r[31:0];
            e.lo  = q[31:0];
            e.lat = XLEN + 1;
        end
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit push);
        op    = o;
        src1  = a;
        src2  = b;
        start = 1'b1;
        if (push) sbq.push_back(model(o, a, b, tag));
        #1;
        chk({tag, "/stall_c0"}, stallreq, 1);
    endtask

    task automatic wait_done(input string tag, input bit hold);
        int   n = 0;
        bit   seen = 0;
        bit   ok = 1;
        exp_t e;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (done === 1'b1) begin
                seen = 1;
                if (sbq.size() == 0) begin
                    chk({tag, "/unexpected_done"}, 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk({e.tag, "/hi"}, hi_wdata, e.hi);
                    chk({e.tag, "/lo"}, lo_wdata, e.lo);
                    chk({e.tag, "/latency"}, n, e.lat);
                    chk({e.tag, "/we_stall_busy"}, {hi_we, lo_we, stallreq, busy}, 4'b1101);
                end
                start = 1'b0;
            end else begin
                if (stallreq !== 1'b1 || hi_we !== 1'b0 || lo_we !== 1'b0) ok = 0;
                if (hold) begin
                    src1 = $urandom;
                    src2 = $urandom;
                    op   = 2'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen) chk({tag, "/timeout"}, 0, 1);
        chk({tag, "/stall_window"}, ok, 1);
        tick();
        chk({tag, "/pulse_end"}, {done, hi_we, lo_we, busy, stallreq}, 0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
        issue(o, a, b, tag, 1);
        wait_done(tag, 0);
    endtask

    initial begin
        bit ok;
        #1;
        chk("reset", {stallreq, busy, done, hi_we, lo_we, hi_wdata, lo_wdata}, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_after_reset", {busy, done, stallreq}, 0);

        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
        run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        run(2'b11, 32'd100, 32'd7, "divu_100_7");
        run(2'b11, 32'h0000_1234, 32'h0, "divu_zero");
        run(2'b10, 32'h8000_0005, 32'h0, "div_zero_signed");
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, "div_pos_neg");

        // cancel a divide at cycle 10; no write may ever appear
        issue(2'b10, 32'd1000, 32'd3, "cancel_div", 0);
        ok = 1;
        for (int i = 1; i < 10; i++) begin
            tick();
            start = 1'b0;
            if (hi_we !== 1'b0 || lo_we !== 1'b0) ok = 0;
        end
        cancel = 1'b1;
        #1;
        chk("cancel/stall_done", {stallreq, done, hi_we}, 0);
        tick();
        cancel = 1'b0;
        #1;
        chk("cancel/idle", busy, 0);
        for (int i = 0; i < 40; i++) begin
            if (hi_we !== 1'b0 || lo_we !== 1'b0) ok = 0;
            if (i == 0) begin
                tick();
                issue(2'b01, 32'd3, 32'd5, "after_cancel", 1);
                wait_done("after_cancel", 0);
                break;
            end
        end
        chk("cancel/no_write", ok, 1);

        // reset in the middle of a divide
        issue(2'b10, 32'd12345, 32'd17, "rst_div", 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("rst_mid", {stallreq, busy, done, hi_we, lo_we, hi_wdata, lo_wdata}, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid/idle", {busy, done}, 0);

        // start held high with changing operands during the operation
        issue(2'b00, 32'hFFFF_FF00, 32'h0001_0003, "hold_mult", 1);
        wait_done("hold_mult", 1);
        issue(2'b11, 32'hDEAD_BEEF, 32'h0000_0101, "hold_divu", 1);
        wait_done("hold_divu", 1);

        for (int i = 0; i < 8; i++)
            run(2'(i), $urandom, (i == 6) ? 32'($urandom_range(1, 9)) : $urandom, $sformatf("rand%0d", i));

        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
